// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use/MDU-scoreboard/branch stall+flush control, RF write-port arbitration, stall counter
module hazard_stall_controller #(
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int WAIT_LIMIT = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
  input  logic                           use_rs1_ID,
  input  logic                           use_rs2_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_ID,
  input  logic                           reg_write_ID,
  input  logic                           mdu_op_ID,
  input  logic                           mem_read_EX,
  input  logic                           reg_write_EX,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
  input  logic                           branch_taken_EX,
  input  logic                           reg_write_WB,
  input  logic                           mdu_result_valid,
  input  logic [REGISTER_ADDR_WIDTH-1:0] mdu_rd,
  output logic                           stall_IF,
  output logic                           stall_ID,
  output logic                           bubble_EX,
  output logic                           flush_IF_ID,
  output logic                           mdu_issue,
  output logic                           mdu_wb_grant,
  output logic                           mdu_busy,
  output logic [CNT_WIDTH-1:0]           stall_cycles
);
  localparam int NREG = 1 << REGISTER_ADDR_WIDTH;
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t r_state, w_next;
  logic [NREG-1:0] r_sb, w_sb_next;
  logic [WW-1:0] r_wait, w_wait_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic w_load_use, w_sb_hz, w_waw, w_struct, w_hz;
  assign w_load_use = mem_read_EX & reg_write_EX & (rd_EX != '0) &
                      ((use_rs1_ID & (rs1_ID == rd_EX)) | (use_rs2_ID & (rs2_ID == rd_EX)));
  assign w_sb_hz = (use_rs1_ID & r_sb[rs1_ID]) | (use_rs2_ID & r_sb[rs2_ID]);
  assign w_waw = reg_write_ID & (rd_ID != '0) & r_sb[rd_ID];
  assign w_struct = mdu_op_ID & (r_state != IDLE);
  assign w_hz = (valid_ID & (w_load_use | w_sb_hz | w_waw | w_struct)) | (r_state == DRAIN);
  assign stall_ID = w_hz & ~branch_taken_EX;
  assign stall_IF = stall_ID;
  assign bubble_EX = w_hz | branch_taken_EX;
  assign flush_IF_ID = branch_taken_EX;
  assign mdu_issue = valid_ID & mdu_op_ID & ~w_hz & ~branch_taken_EX;
  assign mdu_wb_grant = mdu_result_valid & (r_state != IDLE) & ~reg_write_WB;
  assign mdu_busy = r_state != IDLE;
  assign stall_cycles = r_cnt;
  always_comb begin
    w_sb_next = r_sb;
    if (mdu_wb_grant) w_sb_next[mdu_rd] = 1'b0;
    if (mdu_issue && rd_ID != '0) w_sb_next[rd_ID] = 1'b1;
  end
  always_comb begin
    w_next = r_state;
    w_wait_next = r_wait;
    if (mdu_wb_grant) begin
      w_next = IDLE;
      w_wait_next = '0;
    end else if (mdu_issue) begin
      w_next = BUSY;
    end else if (r_state == BUSY && mdu_result_valid) begin
      w_wait_next = r_wait + 1'b1;
      w_next = (w_wait_next == WW'(WAIT_LIMIT)) ? DRAIN : BUSY;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sb <= '0;
      r_wait <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_sb <= w_sb_next;
      r_wait <= w_wait_next;
      r_cnt <= (stall_ID && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the five-stage core. Sits beside the forwarding detector and covers the hazards that forwarding cannot resolve.
- Generates ID stall, EX bubble and IF/ID flush for three cases: load-use, long-latency multiply/divide unit (MDU) dependencies via a register scoreboard, and taken branches.
- Arbitrates the single register-file write port between the WB stage and MDU completion.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REGISTER_ADDR_WIDTH, 5, register index width; the scoreboard holds 2^REGISTER_ADDR_WIDTH bits.
- WAIT_LIMIT, 4, number of consecutive cycles an MDU result may be denied the write port before a drain is forced (must be >= 1).
- CNT_WIDTH, 32, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_ID  in  1  ID holds a real instruction.
- rs1_ID, rs2_ID  in  REGISTER_ADDR_WIDTH  ID source registers.
- use_rs1_ID, use_rs2_ID  in  1  ID instruction reads rs1 / rs2.
- rd_ID  in  REGISTER_ADDR_WIDTH  ID destination register.
- reg_write_ID  in  1  ID instruction writes rd.
- mdu_op_ID  in  1  ID instruction is an MDU op.
- mem_read_EX  in  1  EX instruction is a load.
- reg_write_EX  in  1  EX instruction writes rd.
- rd_EX  in  REGISTER_ADDR_WIDTH  EX destination register.
- branch_taken_EX  in  1  branch/jump resolved taken in EX.
- reg_write_WB  in  1  WB stage uses the RF write port this cycle.
- mdu_result_valid  in  1  MDU result ready; held until granted.
- mdu_rd  in  REGISTER_ADDR_WIDTH  MDU result destination register.
- stall_IF  out  1  hold PC.
- stall_ID  out  1  hold IF/ID register.
- bubble_EX  out  1  load NOP into ID/EX.
- flush_IF_ID  out  1  clear IF/ID register.
- mdu_issue  out  1  MDU op accepted from ID this cycle.
- mdu_wb_grant  out  1  MDU owns the RF write port this cycle.
- mdu_busy  out  1  FSM is not IDLE.
- stall_cycles  out  CNT_WIDTH  saturating stall counter.

Behaviour:
- Reset state: scoreboard = 0, FSM = IDLE, wait counter = 0, stall_cycles = 0.
- All outputs are combinational from registered state plus inputs. All are 0 in reset except any asserted by inputs: a taken branch still flushes.
- Load-use hazard: mem_read_EX & reg_write_EX & rd_EX != 0 & ((use_rs1_ID & rs1_ID == rd_EX) | (use_rs2_ID & rs2_ID == rd_EX)).
- Scoreboard hazard: a used source register has its scoreboard bit set (registered value, no same-cycle bypass).
- WAW hazard: reg_write_ID & rd_ID != 0 & scoreboard[rd_ID].
- Structural hazard: mdu_op_ID & FSM != IDLE.
- Drain: FSM == DRAIN.
- Stall decision: hz = valid_ID & (any of the above hazards), or drain.
- Stall outputs: stall_ID = stall_IF = hz & !branch_taken_EX. bubble_EX = hz | branch_taken_EX. flush_IF_ID = branch_taken_EX. A taken branch overrides every stall.
- Issue: mdu_issue = valid_ID & mdu_op_ID & !hz & !branch_taken_EX.
  - On issue, scoreboard[rd_ID] is set if rd_ID != 0, and FSM moves IDLE -> BUSY.
- Write-port arbitration: mdu_wb_grant = mdu_result_valid & (FSM != IDLE) & !reg_write_WB. WB has priority.
  - On grant, scoreboard[mdu_rd] is cleared and FSM moves to IDLE.
  - If issue and grant target the same register in the same cycle, set wins. In practice this cannot occur because issue needs IDLE.
- FSM states: IDLE, BUSY, DRAIN.
  - BUSY: each cycle with mdu_result_valid & !grant increments the wait counter. When the counter reaches WAIT_LIMIT, go to DRAIN.
  - DRAIN: forces bubbles until a grant occurs, then goes to IDLE and clears the wait counter.
  - A grant in BUSY goes to IDLE and clears the wait counter.
- x0 is never marked busy.
- stall_cycles increments on every cycle stall_ID = 1 and holds at all-ones.
- Reset mid-operation (any state) returns to IDLE with the scoreboard cleared. The MDU is reset by the same rst.

Test Plan:
- Load-use: lw x5 in EX (mem_read_EX=1, rd_EX=5) with add reading rs1_ID=5 -> stall_ID=stall_IF=bubble_EX=1 for exactly 1 cycle; stall_cycles 0 -> 1.
- MDU scoreboard: issue div rd_ID=7, then an instruction reading x7 -> stalled until the mdu_wb_grant cycle for mdu_rd=7; released the next cycle; scoreboard[7]=0.
- Port contention: mdu_result_valid=1 with reg_write_WB=1 for 2 cycles -> mdu_wb_grant=0, then 1 in the first cycle reg_write_WB=0; mdu_busy falls the following cycle.
- Starvation: reg_write_WB held 1 with a pending result, WAIT_LIMIT=4 -> DRAIN entered after 4 denials; bubble_EX=1 each cycle until reg_write_WB drops, then grant.
- Flush priority: load-use hazard and branch_taken_EX together -> flush_IF_ID=1, bubble_EX=1, stall_ID=0, mdu_issue=0 even if mdu_op_ID=1.
- Reset in BUSY: assert rst asynchronously mid-cycle -> mdu_busy=0 immediately, scoreboard cleared, stall_cycles=0.
